// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// last-grant encoding and the full-word byte-enable pattern.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        CPU_RMW = 2'd2,
        DEV_RD  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DEV = 1'b1
    } gnt_t;

    localparam logic [3:0] BYTEEN_FULL = 4'b1111;

endpackage

// File: rtl/dmem_arbiter_byte_merge.sv
// Byte-lane merge for CPU sub-word stores: enabled lanes come from the new
// word, the rest keep the old word read back from memory.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-write-only data RAM between the CPU
// M-stage port and a full-word device port, with read-modify-write for CPU sub-word stores.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_byteen,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,

    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [MEM_AW-1:0] dev_addr,
    input  logic [31:0]       dev_wdata,
    output logic              dev_gnt,
    output logic              dev_rvalid,
    output logic [31:0]       dev_rdata,

    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t        state, state_next;
    gnt_t              last_gnt, last_gnt_next;
    logic [31:0]       dev_rdata_q;
    logic [31:0]       merged_word;
    logic [MEM_AW-1:0] cpu_word;
    logic              cpu_full, cpu_read;
    logic              pick_cpu, pick_dev;
    logic              unused_addr_bits;

    assign cpu_word         = cpu_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:MEM_AW+2], cpu_addr[1:0]};
    assign cpu_full         = (cpu_byteen == BYTEEN_FULL);
    assign cpu_read         = (cpu_byteen == 4'b0000);

    // On a tie the requester that was not served last wins; reset low blocks all grants
    assign pick_cpu = reset && cpu_req && (!dev_req || (last_gnt == GNT_DEV));
    assign pick_dev = reset && dev_req && !pick_cpu;

    byte_merge u_byte_merge (
        .old_word (mem_rdata),
        .new_word (cpu_wdata),
        .byteen   (cpu_byteen),
        .merged   (merged_word)
    );

    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = 32'h0;
        cpu_rdata     = 32'h0;
        cpu_stall     = cpu_req;
        dev_gnt       = 1'b0;
        dev_rvalid    = 1'b0;

        case (state)
            IDLE: begin
                if (pick_cpu) begin
                    last_gnt_next = GNT_CPU;
                    mem_addr      = cpu_word;
                    if (cpu_full) begin
                        mem_we    = 1'b1;
                        mem_wdata = cpu_wdata;
                        cpu_stall = 1'b0;
                    end else begin
                        mem_re     = 1'b1;
                        state_next = cpu_read ? CPU_RD : CPU_RMW;
                    end
                end else if (pick_dev) begin
                    last_gnt_next = GNT_DEV;
                    dev_gnt       = 1'b1;
                    mem_addr      = dev_addr;
                    if (dev_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = dev_wdata;
                    end else begin
                        mem_re     = 1'b1;
                        state_next = DEV_RD;
                    end
                end
            end
            CPU_RD: begin
                cpu_rdata  = mem_rdata;
                cpu_stall  = 1'b0;
                state_next = IDLE;
            end
            CPU_RMW: begin
                mem_addr   = cpu_word;
                mem_we     = 1'b1;
                mem_wdata  = merged_word;
                cpu_stall  = 1'b0;
                state_next = IDLE;
            end
            DEV_RD: begin
                dev_rvalid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Device read data is visible in the rvalid cycle and held in a register afterwards
    assign dev_rdata = (state == DEV_RD) ? mem_rdata : dev_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_gnt    <= GNT_DEV;
            dev_rdata_q <= 32'h0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            if (state == DEV_RD) begin
                dev_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// CPU/device request pairs checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int MEM_AW = 12;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_byteen;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              dev_req;
    logic              dev_we;
    logic [MEM_AW-1:0] dev_addr;
    logic [31:0]       dev_wdata;
    logic              dev_gnt;
    logic              dev_rvalid;
    logic [31:0]       dev_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       ram_q;
    logic              bd_we = 1'b0;
    logic [MEM_AW-1:0] bd_addr = '0;
    logic [31:0]       bd_data = '0;

    logic [31:0]       model_mem [DEPTH];
    logic              model_last_dev;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dev_req    (dev_req),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_gnt    (dev_gnt),
        .dev_rvalid (dev_rvalid),
        .dev_rdata  (dev_rdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous single-port RAM with a backdoor write port for preloading
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) ram_q <= ram[mem_addr];
    end

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_addr = 32'h0; cpu_byteen = 4'h0; cpu_wdata = 32'h0;
        dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = 32'h0;
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_last_dev = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_byteen = 4'h0; cpu_addr = 32'h14;
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 12'd3; dev_wdata = 32'hCAFEF00D;
        #1;
        checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_re: got %b want 0", mem_re); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (dev_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_dev_gnt: got %b want 0", dev_gnt); end
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dev_rvalid: got %b want 0", dev_rvalid); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        checks++; if (dev_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_dev_rdata: got %h want 0", dev_rdata); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_req1: got %b want 1", cpu_stall); end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_req0: got %b want 0", cpu_stall); end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        model_last_dev = 1'b1;
    endtask

    task automatic test_cpu_read();
        preload(12'd5, 32'hDEADBEEF);
        @(negedge clk);
        cpu_req = 1'b1; cpu_byteen = 4'h0; cpu_addr = 32'h14;
        #1;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("[TB] FAIL rd_mem_re: got %b want 1", mem_re); end
        checks++; if (mem_addr !== 12'd5) begin errors++; $display("[TB] FAIL rd_mem_addr: got %h want 5", mem_addr); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rd_stall_c0: got %b want 1", cpu_stall); end
        @(negedge clk);
        #1;
        checks++; if (cpu_rdata !== model_mem[5]) begin errors++; $display("[TB] FAIL rd_data: got %h want %h", cpu_rdata, model_mem[5]); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rd_stall_c1: got %b want 0", cpu_stall); end
        model_last_dev = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_data_idle: got %h want 0", cpu_rdata); end
    endtask

    task automatic test_cpu_partial_write();
        logic [31:0] exp_w;
        preload(12'd2, 32'h11223344);
        exp_w = merge_ref(model_mem[2], 32'h0000AA00, 4'b0010);
        @(negedge clk);
        cpu_req = 1'b1; cpu_byteen = 4'b0010; cpu_wdata = 32'h0000AA00; cpu_addr = 32'h8;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rmw_stall_c0: got %b want 1", cpu_stall); end
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rmw_strobes_c0: got re=%b we=%b want re=1 we=0", mem_re, mem_we); end
        @(negedge clk);
        #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL rmw_mem_we: got %b want 1", mem_we); end
        checks++; if (mem_wdata !== exp_w) begin errors++; $display("[TB] FAIL rmw_wdata: got %h want %h", mem_wdata, exp_w); end
        checks++; if (mem_addr !== 12'd2) begin errors++; $display("[TB] FAIL rmw_addr: got %h want 2", mem_addr); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rmw_stall_c1: got %b want 0", cpu_stall); end
        model_mem[2] = exp_w;
        model_last_dev = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (ram[2] !== model_mem[2]) begin errors++; $display("[TB] FAIL rmw_ram: got %h want %h", ram[2], model_mem[2]); end
    endtask

    task automatic test_tie();
        logic [31:0] old_w, dx, dy;
        old_w = $urandom(); dx = $urandom(); dy = $urandom();
        preload(12'd7, old_w);
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_byteen = 4'h0; cpu_addr = 32'h1C;
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 12'd7; dev_wdata = dx;
        #1;
        checks++; if (mem_re !== 1'b1 || mem_addr !== 12'd7) begin errors++; $display("[TB] FAIL tie_cpu_first: got re=%b addr=%h want re=1 addr=7", mem_re, mem_addr); end
        checks++; if (dev_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_dev_gnt_c0: got %b want 0", dev_gnt); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL tie_stall_c0: got %b want 1", cpu_stall); end
        @(negedge clk);
        #1;
        checks++; if (cpu_rdata !== model_mem[7]) begin errors++; $display("[TB] FAIL tie_cpu_rdata: got %h want %h", cpu_rdata, model_mem[7]); end
        checks++; if (dev_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_dev_gnt_c1: got %b want 0", dev_gnt); end
        @(negedge clk);
        cpu_byteen = 4'hF; cpu_wdata = dy;
        #1;
        checks++; if (dev_gnt !== 1'b1) begin errors++; $display("[TB] FAIL tie2_dev_gnt: got %b want 1", dev_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_wdata !== dx) begin errors++; $display("[TB] FAIL tie2_dev_write: got we=%b data=%h want we=1 data=%h", mem_we, mem_wdata, dx); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL tie2_cpu_stall: got %b want 1", cpu_stall); end
        model_mem[7] = dx;
        @(negedge clk);
        dev_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== dy) begin errors++; $display("[TB] FAIL tie2_cpu_write: got stall=%b we=%b data=%h want stall=0 we=1 data=%h", cpu_stall, mem_we, mem_wdata, dy); end
        model_mem[7] = dy;
        model_last_dev = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (ram[7] !== model_mem[7]) begin errors++; $display("[TB] FAIL tie_ram: got %h want %h", ram[7], model_mem[7]); end
    endtask

    task automatic test_dev_read();
        preload(12'd9, 32'h0BADF00D);
        @(negedge clk);
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 12'd9;
        #1;
        checks++; if (dev_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 12'd9) begin errors++; $display("[TB] FAIL drd_grant: got gnt=%b re=%b addr=%h want 1 1 9", dev_gnt, mem_re, mem_addr); end
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drd_rvalid_c0: got %b want 0", dev_rvalid); end
        @(negedge clk);
        dev_req = 1'b0;
        #1;
        checks++; if (dev_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL drd_rvalid_c1: got %b want 1", dev_rvalid); end
        checks++; if (dev_rdata !== model_mem[9]) begin errors++; $display("[TB] FAIL drd_data: got %h want %h", dev_rdata, model_mem[9]); end
        model_last_dev = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drd_rvalid_c2: got %b want 0", dev_rvalid); end
        checks++; if (dev_rdata !== model_mem[9]) begin errors++; $display("[TB] FAIL drd_hold: got %h want %h", dev_rdata, model_mem[9]); end
        idle_inputs();
    endtask

    task automatic test_reset_in_rmw();
        preload(12'd3, $urandom());
        @(negedge clk);
        cpu_req = 1'b1; cpu_byteen = 4'b0001; cpu_wdata = $urandom(); cpu_addr = 32'h0000000C;
        #1;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("[TB] FAIL rst_rmw_read: got %b want 1", mem_re); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("[TB] FAIL rst_rmw_strobes: got re=%b we=%b want 0 0", mem_re, mem_we); end
        checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rmw_bus: got addr=%h data=%h want 0 0", mem_addr, mem_wdata); end
        checks++; if (cpu_stall !== 1'b1 || cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rmw_cpu: got stall=%b rdata=%h want 1 0", cpu_stall, cpu_rdata); end
        @(negedge clk);
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_rmw_we_hold: got %b want 0", mem_we); end
        idle_inputs();
        reset = 1'b1;
        model_last_dev = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ram[3] !== model_mem[3]) begin errors++; $display("[TB] FAIL rst_rmw_ram: got %h want %h", ram[3], model_mem[3]); end
    endtask

    task automatic test_back_to_back();
        logic [MEM_AW-1:0] words [6];
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            words[i] = MEM_AW'($urandom_range(16, 31));
            d = $urandom();
            @(negedge clk);
            cpu_req = 1'b1; cpu_byteen = 4'hF; cpu_wdata = d;
            cpu_addr = {$urandom()} & 32'hFFFFC003 | (32'(words[i]) << 2);
            #1;
            checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_%0d_strobe: got we=%b stall=%b want 1 0", i, mem_we, cpu_stall); end
            checks++; if (mem_addr !== words[i] || mem_wdata !== d) begin errors++; $display("[TB] FAIL b2b_%0d_bus: got addr=%h data=%h want %h %h", i, mem_addr, mem_wdata, words[i], d); end
            model_mem[words[i]] = d;
        end
        model_last_dev = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (ram[words[i]] !== model_mem[words[i]]) begin errors++; $display("[TB] FAIL b2b_ram_%0d: got %h want %h", i, ram[words[i]], model_mem[words[i]]); end
        end
    endtask

    // Transaction-level model: order the pair by round-robin, apply effects in grant order
    task automatic test_random();
        int          cpu_op, dev_op, cpu_done, dev_gnt_cyc, dev_rv_cyc;
        int          exp_cpu_done, exp_dev_gnt, cpu_occ, dev_occ, cpu_lat;
        logic        cpu_first;
        logic [MEM_AW-1:0] cw, dw;
        logic [31:0] cdata, ddata, cpu_rd_seen, dev_rd_seen, exp_cpu_rd, exp_dev_rd;
        logic [3:0]  be;
        for (int w = 0; w < 8; w++) preload(MEM_AW'(w), $urandom());
        for (int s = 0; s < 40; s++) begin
            cpu_op = $urandom_range(0, 3);
            dev_op = $urandom_range(0, 2);
            if (cpu_op == 0 && dev_op == 0) cpu_op = 1;
            cw = MEM_AW'($urandom_range(0, 7));
            dw = MEM_AW'($urandom_range(0, 7));
            cdata = $urandom(); ddata = $urandom();
            be = (cpu_op == 1) ? 4'h0 : (cpu_op == 3) ? 4'hF : 4'($urandom_range(1, 14));

            cpu_first = (cpu_op != 0) && (dev_op == 0 || model_last_dev);
            cpu_occ = (cpu_op == 3) ? 1 : 2;
            dev_occ = (dev_op == 2) ? 1 : 2;
            cpu_lat = (cpu_op == 3) ? 0 : 1;
            exp_cpu_done = cpu_first ? cpu_lat : dev_occ + cpu_lat;
            exp_dev_gnt  = (cpu_op != 0 && cpu_first) ? cpu_occ : 0;
            exp_cpu_rd = 32'h0; exp_dev_rd = 32'h0;
            if (cpu_first) begin
                exp_cpu_rd = model_mem[cw];
                if (cpu_op >= 2) model_mem[cw] = merge_ref(model_mem[cw], cdata, be);
                exp_dev_rd = model_mem[dw];
                if (dev_op == 2) model_mem[dw] = ddata;
            end else begin
                exp_dev_rd = model_mem[dw];
                if (dev_op == 2) model_mem[dw] = ddata;
                exp_cpu_rd = model_mem[cw];
                if (cpu_op >= 2) model_mem[cw] = merge_ref(model_mem[cw], cdata, be);
            end
            if (cpu_op != 0 && dev_op != 0) model_last_dev = cpu_first;
            else model_last_dev = (cpu_op == 0);

            cpu_done = -1; dev_gnt_cyc = -1; dev_rv_cyc = -1;
            cpu_rd_seen = 32'h0; dev_rd_seen = 32'h0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                if (cyc == 0) begin
                    cpu_req = (cpu_op != 0); cpu_byteen = be; cpu_wdata = cdata;
                    cpu_addr = ($urandom() & 32'hFFFFC003) | (32'(cw) << 2);
                    dev_req = (dev_op != 0); dev_we = (dev_op == 2); dev_addr = dw; dev_wdata = ddata;
                end else begin
                    if (cpu_done >= 0) cpu_req = 1'b0;
                    if (dev_gnt_cyc >= 0) dev_req = 1'b0;
                end
                #1;
                if (cpu_req && !cpu_stall && cpu_done < 0) begin cpu_done = cyc; cpu_rd_seen = cpu_rdata; end
                if (dev_gnt && dev_gnt_cyc < 0) dev_gnt_cyc = cyc;
                if (dev_rvalid && dev_rv_cyc < 0) begin dev_rv_cyc = cyc; dev_rd_seen = dev_rdata; end
                if ((cpu_op == 0 || cpu_done >= 0) && (dev_op == 0 || dev_gnt_cyc >= 0) &&
                    (dev_op != 1 || dev_rv_cyc >= 0)) break;
            end
            if (cpu_op != 0) begin
                checks++; if (cpu_done != exp_cpu_done) begin errors++; $display("[TB] FAIL rnd%0d_cpu_done: got cycle %0d want %0d", s, cpu_done, exp_cpu_done); end
            end
            if (cpu_op == 1) begin
                checks++; if (cpu_rd_seen !== exp_cpu_rd) begin errors++; $display("[TB] FAIL rnd%0d_cpu_rdata: got %h want %h", s, cpu_rd_seen, exp_cpu_rd); end
            end
            if (dev_op != 0) begin
                checks++; if (dev_gnt_cyc != exp_dev_gnt) begin errors++; $display("[TB] FAIL rnd%0d_dev_gnt: got cycle %0d want %0d", s, dev_gnt_cyc, exp_dev_gnt); end
            end
            if (dev_op == 1) begin
                checks++; if (dev_rv_cyc != exp_dev_gnt + 1) begin errors++; $display("[TB] FAIL rnd%0d_dev_rvalid: got cycle %0d want %0d", s, dev_rv_cyc, exp_dev_gnt + 1); end
                checks++; if (dev_rd_seen !== exp_dev_rd) begin errors++; $display("[TB] FAIL rnd%0d_dev_rdata: got %h want %h", s, dev_rd_seen, exp_dev_rd); end
            end
            @(negedge clk);
            idle_inputs();
        end
        @(negedge clk);
        #1;
        for (int w = 0; w < 8; w++) begin
            checks++; if (ram[w] !== model_mem[w]) begin errors++; $display("[TB] FAIL rnd_ram_%0d: got %h want %h", w, ram[w], model_mem[w]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        model_last_dev = 1'b1;
        idle_inputs();
        #1 reset = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_partial_write();
        test_tie();
        test_dev_read();
        test_reset_in_rmw();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
